// File: rtl/coeff_stream_loader_pkg.sv
// Shared types and word widths for the coefficient stream loader.
// Exports the FSM state enum and the real/complex word widths.
`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

package LoaderPkg;
  localparam int WORD_W = `OVERALL_BITS;
  localparam int PAIR_W = 2 * WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    GET_RE,
    GET_IM,
    STROBE,
    FINISH
  } state_e;
endpackage

// File: rtl/coeff_stream_loader_if.sv
// Valid/ready word stream carrying alternating real and imaginary words.
// master drives s_data/s_valid, slave drives s_ready.
interface coeff_stream_loader_if;
  logic [LoaderPkg::WORD_W-1:0] s_data;
  logic                         s_valid;
  logic                         s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/coeff_stream_loader.sv
// Pairs re/im stream words into complex coefficients, one isolated strobe each.
// Ports: clk, rst_n, start/start_addr/num_coeffs/expand_mode_in, stream s, write bus, busy, done.
module coeff_stream_loader
  import LoaderPkg::*;
#(
  parameter int LOGN = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LOGN-1:0]   start_addr,
  input  logic [LOGN:0]     num_coeffs,
  input  logic              expand_mode_in,
  coeff_stream_loader_if.slave s,
  output logic [LOGN-1:0]   addr_to_expand,
  output logic [PAIR_W-1:0] data_to_expand,
  output logic              wea_to_expand,
  output logic              do_expand,
  output logic              busy,
  output logic              done
);

  state_e            state;
  logic [LOGN-1:0]   addr_q;
  logic [LOGN:0]     rem_q;
  logic [WORD_W-1:0] re_q;
  logic              hs;

  assign s.s_ready     = (state == GET_RE) || (state == GET_IM);
  assign hs            = s.s_valid && s.s_ready;
  assign wea_to_expand = (state == STROBE);
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      re_q           <= '0;
      do_expand      <= 1'b0;
      addr_to_expand <= '0;
      data_to_expand <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= start_addr;
            rem_q     <= num_coeffs;
            do_expand <= expand_mode_in;
            state     <= (num_coeffs == '0) ? FINISH : GET_RE;
          end
        end
        GET_RE: begin
          if (hs) begin
            re_q  <= s.s_data;
            state <= GET_IM;
          end
        end
        GET_IM: begin
          // Output bus is loaded here so it is stable for the whole strobe.
          if (hs) begin
            data_to_expand <= {re_q, s.s_data};
            addr_to_expand <= addr_q;
            state          <= STROBE;
          end
        end
        STROBE: begin
          addr_q <= addr_q + LOGN'(1);
          rem_q  <= rem_q - (LOGN+1)'(1);
          state  <= (rem_q == (LOGN+1)'(1)) ? FINISH : GET_RE;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_stream_loader.sv
// Randomized self-checking bench for coeff_stream_loader.
// Expected strobes come from a queue of (start_addr+i, {re_i, im_i}).
module tb_coeff_stream_loader;
  import LoaderPkg::*;

  localparam int LOGN = 13;
  localparam int NMAX = 1 << LOGN;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LOGN-1:0]   start_addr;
  logic [LOGN:0]     num_coeffs;
  logic              expand_mode_in;
  logic [LOGN-1:0]   addr_to_expand;
  logic [PAIR_W-1:0] data_to_expand;
  logic              wea_to_expand;
  logic              do_expand;
  logic              busy;
  logic              done;

  coeff_stream_loader_if sif ();

  coeff_stream_loader #(.LOGN(LOGN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .num_coeffs     (num_coeffs),
    .expand_mode_in (expand_mode_in),
    .s              (sif),
    .addr_to_expand (addr_to_expand),
    .data_to_expand (data_to_expand),
    .wea_to_expand  (wea_to_expand),
    .do_expand      (do_expand),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [WORD_W-1:0] words[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    words.delete();
    for (int i = 0; i < 2 * n; i++)
      words.push_back(WORD_W'($urandom));
  endtask

  task automatic run_load(input string name, input logic [LOGN-1:0] sa,
                          input logic mode, input int gap_pct,
                          input bit poke);
    int n;
    int cyc;
    int k;
    int w;
    int last;
    bit prev;
    bit fin;
    bit hs;
    logic [LOGN-1:0]   ea;
    logic [PAIR_W-1:0] ed;
    n = words.size() / 2;
    start = 1'b1;
    start_addr = sa;
    num_coeffs = (LOGN+1)'(n);
    expand_mode_in = mode;
    sif.s_valid = 1'b0;
    step();
    start = 1'b0;
    cyc = 1; k = 0; w = 0; last = 0; prev = 1'b0; fin = 1'b0;
    while (!fin && cyc < 20 * n + 50) begin
      total++;
      if (busy !== 1'b1 || do_expand !== mode)
        $display("FAIL %s busy/mode cyc %0d: busy=%b do_expand=%b want 1/%b",
                 name, cyc, busy, do_expand, mode);
      else passed++;
      if (n == 0) begin
        total++;
        if (sif.s_ready !== 1'b0 || wea_to_expand !== 1'b0)
          $display("FAIL %s zero ready/wea: %b/%b want 0/0",
                   name, sif.s_ready, wea_to_expand);
        else passed++;
      end
      if (wea_to_expand === 1'b1) begin
        ea = LOGN'((int'(sa) + k) % NMAX);
        ed = (k < n) ? {words[2*k], words[2*k+1]} : '0;
        total++;
        if (prev || k >= n || addr_to_expand !== ea || data_to_expand !== ed)
          $display("FAIL %s strobe %0d: prev=%b addr=%h data=%h want addr=%h data=%h",
                   name, k, prev, addr_to_expand, data_to_expand, ea, ed);
        else passed++;
        if (gap_pct == 0) begin
          total++;
          if (cyc != (k == 0 ? 3 : last + 3))
            $display("FAIL %s strobe %0d timing: cycle %0d want %0d",
                     name, k, cyc, (k == 0 ? 3 : last + 3));
          else passed++;
        end
        last = cyc;
        k++;
      end
      if (done === 1'b1) begin
        fin = 1'b1;
        total++;
        if (k != n || w != 2 * n)
          $display("FAIL %s counts: strobes=%0d words=%0d want %0d/%0d",
                   name, k, w, n, 2 * n);
        else passed++;
        if (gap_pct == 0) begin
          total++;
          if (cyc != (n == 0 ? 1 : last + 1))
            $display("FAIL %s done timing: cycle %0d want %0d",
                     name, cyc, (n == 0 ? 1 : last + 1));
          else passed++;
        end
      end
      prev = wea_to_expand;
      if (!fin) begin
        sif.s_valid = ($urandom_range(99) >= gap_pct);
        sif.s_data = (w < words.size()) ? words[w] : WORD_W'($urandom);
        hs = sif.s_valid && sif.s_ready;
        if (poke && cyc == 4) begin
          start = 1'b1;
          start_addr = ~sa;
          expand_mode_in = ~mode;
          num_coeffs = (LOGN+1)'(1);
        end
        step();
        start = 1'b0;
        if (hs) w++;
        cyc++;
      end
    end
    total++;
    if (!fin)
      $display("FAIL %s timeout: done=%b want 1", name, done);
    else passed++;
    sif.s_valid = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.s_ready !== 1'b0)
      $display("FAIL %s idle after: busy=%b done=%b ready=%b want 0/0/0",
               name, busy, done, sif.s_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    num_coeffs = '0;
    expand_mode_in = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    #3;
    total++;
    if ({busy, done, wea_to_expand, do_expand, sif.s_ready} !== 5'b0 ||
        addr_to_expand !== '0 || data_to_expand !== '0)
      $display("FAIL reset outputs: b%b d%b w%b x%b r%b a=%h dat=%h want zeros",
               busy, done, wea_to_expand, do_expand, sif.s_ready,
               addr_to_expand, data_to_expand);
    else passed++;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    words = '{WORD_W'('h11), WORD_W'('h22), WORD_W'('h33), WORD_W'('h44)};
    run_load("basic", '0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      fill(10 + i * 3);
      run_load("gaps", LOGN'($urandom), 1'(i), 30 + i * 10, 1'b0);
    end
  endtask

  task automatic test_wrap();
    fill(3);
    run_load("wrap", LOGN'(NMAX - 1), 1'b0, 0, 1'b0);
  endtask

  task automatic test_full_count();
    fill(NMAX);
    run_load("full", LOGN'(100), 1'b1, 0, 1'b0);
  endtask

  task automatic test_zero_count();
    words.delete();
    run_load("zero", LOGN'(55), 1'b1, 0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    fill(5);
    run_load("busy_start", LOGN'(40), 1'b0, 0, 1'b1);
    fill(5);
    run_load("busy_start2", LOGN'(7), 1'b1, 20, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    fill(2);
    start = 1'b1;
    start_addr = LOGN'(5);
    num_coeffs = (LOGN+1)'(2);
    expand_mode_in = 1'b1;
    step();
    start = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data = words[0];
    step();
    sif.s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, wea_to_expand, do_expand, sif.s_ready} !== 5'b0 ||
        addr_to_expand !== '0 || data_to_expand !== '0)
      $display("FAIL midreset outputs: b%b d%b w%b x%b r%b a=%h dat=%h want zeros",
               busy, done, wea_to_expand, do_expand, sif.s_ready,
               addr_to_expand, data_to_expand);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (wea_to_expand !== 1'b0 || busy !== 1'b0)
        $display("FAIL midreset hold %0d: wea=%b busy=%b want 0/0",
                 i, wea_to_expand, busy);
      else passed++;
    end
    rst_n = 1'b1;
    step();
    fill(3);
    run_load("after_reset", LOGN'(9), 1'b0, 25, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_count();
    test_start_while_busy();
    test_reset_mid_load();
    test_full_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
